// File: rtl/bp_fpga_host_nbf_uart_tx_if.sv
`default_nettype none
// ==== bp_fpga_host_nbf_uart_tx_if : NBF packet in / UART line out bundle, rev 1.0 ====
interface bp_fpga_host_nbf_uart_tx_if #(
  parameter int NBF_WIDTH = 112
);
  logic [NBF_WIDTH-1:0] i_nbf;
  logic                 i_nbf_v;
  logic                 o_nbf_ready_and;
  logic                 o_tx;
  logic                 o_busy;

  modport master (
    output i_nbf, i_nbf_v,
    input  o_nbf_ready_and, o_tx, o_busy
  );

  modport slave (
    input  i_nbf, i_nbf_v,
    output o_nbf_ready_and, o_tx, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/bp_fpga_host_nbf_uart_tx.sv
`default_nettype none
// ==== bp_fpga_host_nbf_uart_tx : serializes whole NBF packets onto a UART tx line, rev 1.0 ====
module bp_fpga_host_nbf_uart_tx #(
  parameter int NBF_ADDR_WIDTH   = 40,
  parameter int NBF_DATA_WIDTH   = 64,
  parameter int UART_CLK_PER_BIT = 10416,
  parameter int UART_DATA_BITS   = 8,
  parameter int UART_PARITY_BIT  = 0,
  parameter int UART_PARITY_ODD  = 0,
  parameter int UART_STOP_BITS   = 1
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  bp_fpga_host_nbf_uart_tx_if.slave    bus
);
  localparam int   NBF_WIDTH = 8 + NBF_ADDR_WIDTH + NBF_DATA_WIDTH;
  localparam int   NBF_BYTES = NBF_WIDTH / 8;
  localparam int   CLK_W     = $clog2(UART_CLK_PER_BIT);
  localparam int   BC_W      = (NBF_BYTES > 1) ? $clog2(NBF_BYTES) : 1;
  localparam logic PAR_ODD   = (UART_PARITY_ODD != 0);

  if (UART_DATA_BITS != 8 || (UART_STOP_BITS != 1 && UART_STOP_BITS != 2) ||
      UART_CLK_PER_BIT < 2 || (NBF_WIDTH % 8) != 0) begin : g_param_err
    $error("bp_fpga_host_nbf_uart_tx: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state,    w_state_nxt;
  logic [NBF_WIDTH-1:0] r_shift,    w_shift_nxt;
  logic [BC_W-1:0]      r_byte_cnt, w_byte_cnt_nxt;
  logic [2:0]           r_bit_cnt,  w_bit_cnt_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic [CLK_W-1:0]     r_clk_cnt,  w_clk_cnt_nxt;
  logic                 r_tx,       w_tx_nxt;
  logic                 w_ready;
  logic                 w_tick;
  logic [7:0]           w_byte_nxt;

  assign w_ready = (r_state == S_IDLE) & ~rst;
  assign w_tick  = (r_clk_cnt == CLK_W'(UART_CLK_PER_BIT - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_byte_cnt_nxt = r_byte_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_clk_cnt_nxt  = '0;
    if (r_state != S_IDLE)
      w_clk_cnt_nxt = w_tick ? '0 : r_clk_cnt + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (bus.i_nbf_v & w_ready) begin
          w_state_nxt    = S_START;
          w_shift_nxt    = bus.i_nbf;
          w_byte_cnt_nxt = '0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt    = (UART_PARITY_BIT != 0) ? S_PARITY : S_STOP;
            w_stop_cnt_nxt = 1'b0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt    = S_STOP;
          w_stop_cnt_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_stop_cnt != 1'(UART_STOP_BITS - 1)) begin
            w_stop_cnt_nxt = 1'b1;
          end else if (r_byte_cnt != BC_W'(NBF_BYTES - 1)) begin
            // Next byte starts with no idle gap; bring it down to the low byte.
            w_state_nxt    = S_START;
            w_byte_cnt_nxt = r_byte_cnt + 1'b1;
            w_shift_nxt    = r_shift >> 8;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // tx is registered from the next-state view so the line changes exactly on bit boundaries.
    w_byte_nxt = w_shift_nxt[7:0];
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_byte_nxt[w_bit_cnt_nxt];
      S_PARITY: w_tx_nxt = (^w_byte_nxt) ^ PAR_ODD;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_clk_cnt  <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  assign bus.o_nbf_ready_and = w_ready;
  assign bus.o_tx            = r_tx;
  assign bus.o_busy          = (r_state != S_IDLE);

  a_nbf_v_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(bus.i_nbf_v));

endmodule
`default_nettype wire

// File: tb/tb_bp_fpga_host_nbf_uart_tx.sv
`default_nettype none
// ==== tb_bp_fpga_host_nbf_uart_tx : bench for the NBF UART serializer, rev 1.0 ====
module tb_bp_fpga_host_nbf_uart_tx;
  localparam int CPB = 4;
  localparam int NW  = 112;
  localparam int NB  = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_fpga_host_nbf_uart_tx_if #(.NBF_WIDTH(NW)) if_a ();
  bp_fpga_host_nbf_uart_tx_if #(.NBF_WIDTH(NW)) if_b ();
  bp_fpga_host_nbf_uart_tx_if #(.NBF_WIDTH(NW)) if_c ();

  // a: no parity, 1 stop; b: even parity, 2 stops; c: odd parity, 1 stop
  bp_fpga_host_nbf_uart_tx #(.UART_CLK_PER_BIT(CPB)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  bp_fpga_host_nbf_uart_tx #(.UART_CLK_PER_BIT(CPB), .UART_PARITY_BIT(1),
    .UART_PARITY_ODD(0), .UART_STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  bp_fpga_host_nbf_uart_tx #(.UART_CLK_PER_BIT(CPB), .UART_PARITY_BIT(1),
    .UART_PARITY_ODD(1), .UART_STOP_BITS(1)) u_dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  logic [NW-1:0] nbf_d [3];
  logic          v_d   [3];
  logic          tx_w  [3];
  logic          rdy_w [3];
  logic          busy_w[3];

  assign if_a.i_nbf = nbf_d[0]; assign if_a.i_nbf_v = v_d[0];
  assign if_b.i_nbf = nbf_d[1]; assign if_b.i_nbf_v = v_d[1];
  assign if_c.i_nbf = nbf_d[2]; assign if_c.i_nbf_v = v_d[2];
  assign tx_w[0] = if_a.o_tx; assign rdy_w[0] = if_a.o_nbf_ready_and; assign busy_w[0] = if_a.o_busy;
  assign tx_w[1] = if_b.o_tx; assign rdy_w[1] = if_b.o_nbf_ready_and; assign busy_w[1] = if_b.o_busy;
  assign tx_w[2] = if_c.o_tx; assign rdy_w[2] = if_c.o_nbf_ready_and; assign busy_w[2] = if_c.o_busy;

  int   par_en [3] = '{0, 1, 1};
  bit   par_odd[3] = '{1'b0, 1'b0, 1'b1};
  int   stops  [3] = '{1, 2, 1};

  int   tests = 0;
  int   fails = 0;
  logic last_par;
  logic exp_q[$];
  int   wc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] rand_pkt();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[NW-1:0];
  endfunction

  // Reference: the UART bit list of a whole packet, one entry per bit period.
  task automatic build(input int d, input logic [NW-1:0] pkt);
    logic [7:0] by;
    exp_q.delete();
    for (int k = 0; k < NB; k++) begin
      by = pkt[8*k +: 8];
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(by[i]);
      if (par_en[d] != 0) exp_q.push_back((^by) ^ par_odd[d]);
      for (int s = 0; s < stops[d]; s++) exp_q.push_back(1'b1);
    end
  endtask

  // Entered and left on a negedge. Checks the tx line every cycle of the packet.
  task automatic run_pkt(input int d, input logic [NW-1:0] pkt, input bit hold_v,
                         input bit toggle_v, input string tag, output int wait_cyc);
    int n, bad, rdy_hi, busy_lo;
    build(d, pkt);
    n = exp_q.size() * CPB;
    nbf_d[d] = pkt;
    v_d[d]   = 1'b1;
    wait_cyc = 0;
    while (!rdy_w[d] && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, " accept"}, 32'(rdy_w[d]), 32'd1);
    @(negedge clk);
    if (!hold_v) v_d[d] = 1'b0;
    bad = 0; rdy_hi = 0; busy_lo = 0;
    for (int c = 0; c < n; c++) begin
      if (tx_w[d] !== exp_q[c / CPB]) bad++;
      if (rdy_w[d] !== 1'b0) rdy_hi++;
      if (busy_w[d] !== 1'b1) busy_lo++;
      if (c == 9*CPB + CPB/2) last_par = tx_w[d];
      if (toggle_v) begin
        v_d[d]   = (c < n - 2) ? 1'($urandom) : 1'b0;
        nbf_d[d] = rand_pkt();
      end
      @(negedge clk);
    end
    check({tag, " tx bit errors"}, 32'(bad), 32'd0);
    check({tag, " ready high in packet"}, 32'(rdy_hi), 32'd0);
    check({tag, " busy low in packet"}, 32'(busy_lo), 32'd0);
    check({tag, " ready at end"}, 32'(rdy_w[d]), 32'd1);
    check({tag, " tx idle at end"}, 32'(tx_w[d]), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      nbf_d[d] = '0;
      v_d[d]   = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset tx d%0d", d), 32'(tx_w[d]), 32'd1);
      check($sformatf("reset ready d%0d", d), 32'(rdy_w[d]), 32'd0);
      check($sformatf("reset busy d%0d", d), 32'(busy_w[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post-reset ready", 32'(rdy_w[0]), 32'd1);
    check("post-reset tx", 32'(tx_w[0]), 32'd1);

    run_pkt(0, {64'h0123456789ABCDEF, 40'h00_8000_0000, 8'h02}, 1'b0, 1'b0, "fixed pkt", wc);
    repeat (2) run_pkt(0, rand_pkt(), 1'b0, 1'b0, "random pkt a", wc);

    run_pkt(1, {rand_pkt() >> 8, 8'h07}, 1'b0, 1'b0, "even parity pkt", wc);
    check("even parity of 0x07", 32'(last_par), 32'd1);
    run_pkt(2, {rand_pkt() >> 8, 8'h07}, 1'b0, 1'b0, "odd parity pkt", wc);
    check("odd parity of 0x07", 32'(last_par), 32'd0);
    run_pkt(1, rand_pkt(), 1'b0, 1'b0, "random pkt b", wc);
    run_pkt(2, rand_pkt(), 1'b0, 1'b0, "random pkt c", wc);

    run_pkt(0, rand_pkt(), 1'b1, 1'b0, "b2b pkt0", wc);
    run_pkt(0, rand_pkt(), 1'b1, 1'b0, "b2b pkt1", wc);
    check("b2b gap1 wait", 32'(wc), 32'd0);
    run_pkt(0, rand_pkt(), 1'b0, 1'b0, "b2b pkt2", wc);
    check("b2b gap2 wait", 32'(wc), 32'd0);

    run_pkt(0, rand_pkt(), 1'b0, 1'b1, "valid toggled while busy", wc);

    nbf_d[0] = rand_pkt();
    v_d[0]   = 1'b1;
    wc = 0;
    while (!rdy_w[0] && wc < 2000) begin
      @(negedge clk);
      wc++;
    end
    @(negedge clk);
    v_d[0] = 1'b0;
    repeat (5 * 10 * CPB + 1) @(negedge clk);
    check("byte5 start bit before reset", 32'(tx_w[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("mid-packet reset tx", 32'(tx_w[0]), 32'd1);
    check("mid-packet reset ready", 32'(rdy_w[0]), 32'd0);
    check("mid-packet reset busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pkt(0, rand_pkt(), 1'b0, 1'b0, "pkt after reset", wc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
